sr_jk_ff: RTL and testbench



---
 rtl/sr_jk_ff_pkg.sv | 23 ++
 rtl/sr_ff.sv | 46 ++++
 rtl/sr_jk_ff.sv | 59 +++++
 tb/tb_sr_jk_ff.sv | 135 +++++++++++++
 4 files changed

// File: rtl/sr_jk_ff_pkg.sv
// -----------------------------------------------------------------------------
// sr_jk_ff_pkg
//   Shared definitions for the T flip-flop built on an SR core.
//   - sr_cmd_e : SR command encoding, packed as {s, r}
//   - t_to_sr  : excitation function mapping (t, current q) to an SR command
//   Optional macro used by the block: SR_JK_FF_ASSERT_EN (see sr_jk_ff.sv).
// -----------------------------------------------------------------------------
package sr_jk_ff_pkg;

   typedef enum logic [1:0] {
      SR_HOLD    = 2'b00,
      SR_RESET   = 2'b01,
      SR_SET     = 2'b10,
      SR_ILLEGAL = 2'b11
   } sr_cmd_e;

   // Toggle request becomes "set" when q is low and "reset" when q is high,
   // so s and r can never both be asserted.
   function automatic sr_cmd_e t_to_sr(input logic t, input logic q);
      return sr_cmd_e'({t & ~q, t & q});
   endfunction

endpackage

// File: rtl/sr_ff.sv
// -----------------------------------------------------------------------------
// sr_ff
//   Single-bit SR flip-flop with asynchronous active-high reset.
//   Ports:
//     clk   in  1  rising-edge clock
//     reset in  1  asynchronous active-high reset, loads RESET_VAL
//     s     in  1  set request
//     r     in  1  reset request
//     q     out 1  registered state
//   Parameter RESET_VAL: value of q while reset is high.
//   s=r=1 is treated as hold.
// -----------------------------------------------------------------------------
module sr_ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic s,
   input  logic r,
   output logic q
);
   import sr_jk_ff_pkg::*;

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      case ({s, r})
         SR_SET:   q_d = 1'b1;
         SR_RESET: q_d = 1'b0;
         default:  q_d = q_q;   // hold, and the unreachable s=r=1 case
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/sr_jk_ff.sv
// -----------------------------------------------------------------------------
// sr_jk_ff
//   Bank of WIDTH independent T flip-flops, each built from an SR core plus
//   excitation logic (s = t & ~q, r = t & q). At each rising clk edge a bit
//   toggles when its t is 1 and holds when t is 0.
//   Ports:
//     clk   in  1      rising-edge clock
//     reset in  1      asynchronous active-high reset, q = RESET_VAL
//     t     in  WIDTH  per-bit toggle request
//     q     out WIDTH  registered state straight from the SR core flops
//   Parameters: WIDTH (bit count), RESET_VAL (WIDTH-bit reset value).
//   Optional macro SR_JK_FF_ASSERT_EN: adds simulation-only checks that s and r
//   are never both set and that q holds RESET_VAL while reset is high.
// -----------------------------------------------------------------------------
module sr_jk_ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q
);
   import sr_jk_ff_pkg::*;

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] r;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign {s[i], r[i]} = t_to_sr(t[i], q[i]);

      sr_ff #(
         .RESET_VAL (RESET_VAL[i])
      ) u_sr_ff (
         .clk   (clk),
         .reset (reset),
         .s     (s[i]),
         .r     (r[i]),
         .q     (q[i])
      );
   end

`ifdef SR_JK_FF_ASSERT_EN
   // Checked at the rising edge, where s/r are actually consumed; reset has
   // already forced q asynchronously by then.
   always @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         assert (!(s[i] && r[i]))
            else $error("%0t: s and r both set on bit %0d", $time, i);
         if (reset) begin
            assert (q[i] == RESET_VAL[i])
               else $error("%0t: q not at reset value during reset on bit %0d", $time, i);
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_sr_jk_ff.sv
// -----------------------------------------------------------------------------
// tb_sr_jk_ff
//   Bench for sr_jk_ff (WIDTH=4, RESET_VAL=0). The driver applies t/reset at
//   the falling edge, advances a behavioural model (reset ? RESET_VAL : q ^ t)
//   and pushes the expected q into exp_q; the monitor pops one entry after
//   every rising edge and compares it with q.
// -----------------------------------------------------------------------------
module tb_sr_jk_ff;
   localparam int           W  = 4;
   localparam logic [W-1:0] RV = '0;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] t;
   logic [W-1:0] q;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] model_q;
   logic [W-1:0] mon_e;

   // ---------------- clock / reset ----------------
   always #10 clk = ~clk;

   sr_jk_ff #(
      .WIDTH     (W),
      .RESET_VAL (RV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .t     (t),
      .q     (q)
   );

   function automatic void check(input string name, input logic [W-1:0] act,
                                 input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- driver tasks ----------------
   // One clock of stimulus; q must still hold the previous expected value
   // at the falling edge (t wiggles between edges must not reach q).
   task automatic cycle(input logic [W-1:0] t_v, input logic rst_v);
      @(negedge clk);
      check("hold_between_edges", q, model_q);
      t     = t_v;
      reset = rst_v;
      model_q = rst_v ? RV : (model_q ^ t_v);
      exp_q.push_back(model_q);
   endtask

   // Asserts reset halfway between a rising and a falling edge.
   task automatic mid_reset();
      @(posedge clk);
      #5;
      reset = 1'b1;
      #1;
      check("async_reset_mid_cycle", q, RV);
      model_q = RV;
   endtask

   // Changes t after the rising edge has sampled it.
   task automatic wiggle_t();
      @(posedge clk);
      #5;
      t = W'($urandom_range(0, (1 << W) - 1));
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("edge_q", q, mon_e);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset   = 1'b0;
      t       = '0;
      model_q = RV;
      #2;
      reset = 1'b1;
      #1;
      check("reset_assert", q, RV);
      #14;
      reset = 1'b0;

      // toggle bit 0 over three edges: 1, 0, 1
      repeat (3) cycle(4'b0001, 1'b0);
      // hold from q=1 across two edges
      repeat (2) cycle(4'b0000, 1'b0);

      // async reset mid-operation, held across an edge, then released with t=1
      cycle(4'b0001, 1'b0);
      mid_reset();
      cycle(4'b0001, 1'b1);
      cycle(4'b0001, 1'b0);

      // multi-bit pattern from reset: 0101 then 0000
      cycle(4'b0000, 1'b1);
      cycle(4'b0101, 1'b0);
      cycle(4'b0101, 1'b0);

      // all bits toggle together
      repeat (2) cycle(4'b1111, 1'b0);

      // randomized t/reset
      for (int i = 0; i < 1000; i++) begin
         cycle(W'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 3) == 0) wiggle_t();
         if ($urandom_range(0, 63) == 0) mid_reset();
      end

      // drain the scoreboard within a bounded number of edges
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
